// File: rtl/riscv_pkg.sv
// Shared types for the pipelined register-file/ALU datapath.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_t;

  // Width-independent part of every stage register; data fields depend on
  // module parameters and are wrapped around this in the datapath.
  typedef struct packed {
    logic    valid;
    logic    reg_write;
    wb_sel_t mem_to_reg;
  } stage_ctrl_t;

  function automatic logic is_load(input stage_ctrl_t c);
    return c.valid & (c.mem_to_reg == WB_MEM);
  endfunction

endpackage

// File: rtl/pipelined_datapath_if.sv
// Decoder-side and memory-side signals of the pipelined datapath.
interface pipelined_datapath_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic             InValid;
  logic             InReady;
  logic             RegWrite;
  alu_op_t          ALUControl;
  logic             ALUSrc;
  logic [IDX_W-1:0] rs1;
  logic [IDX_W-1:0] rs2;
  logic [IDX_W-1:0] rd;
  logic [XLEN-1:0]  Imm;
  logic [XLEN-1:0]  PC;
  wb_sel_t          MemToReg;
  logic             Flush;
  logic [XLEN-1:0]  MemAddr;
  logic             MemRead;
  logic [XLEN-1:0]  ReadDataMem;
  logic             WbValid;
  logic [IDX_W-1:0] WbRd;
  logic [XLEN-1:0]  WriteBackData;

  modport master (
    output InValid, RegWrite, ALUControl, ALUSrc, rs1, rs2, rd, Imm, PC,
           MemToReg, Flush, ReadDataMem,
    input  InReady, MemAddr, MemRead, WbValid, WbRd, WriteBackData
  );

  modport slave (
    input  InValid, RegWrite, ALUControl, ALUSrc, rs1, rs2, rd, Imm, PC,
           MemToReg, Flush, ReadDataMem,
    output InReady, MemAddr, MemRead, WbValid, WbRd, WriteBackData
  );
endinterface

// File: rtl/ALU.sv
// Integer ALU; the zero flag is not needed by this datapath and is omitted.
module ALU
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  // Operation select
  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = XLEN'($signed(a_i) >>> shamt);
      ALU_SLT:  result_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU: result_o = XLEN'(a_i < b_i);
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/hazard_unit.sv
// Combinational forwarding-select and stall decision for the operand-read stage.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int unsigned IDX_W  = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [IDX_W-1:0] rs1_i,
  input  logic [IDX_W-1:0] rs2_i,
  input  logic             rs2_used_i,
  input  logic             ex_valid_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_is_load_i,
  input  logic [IDX_W-1:0] ex_rd_i,
  input  logic             wb_valid_i,
  input  logic             wb_reg_write_i,
  input  logic [IDX_W-1:0] wb_rd_i,
  input  logic             flush_i,
  output fwd_sel_t         fwd_a_o,
  output fwd_sel_t         fwd_b_o,
  output logic             stall_o
);
  function automatic logic hit(input logic v, input logic rw,
                               input logic [IDX_W-1:0] rd,
                               input logic [IDX_W-1:0] src);
    return v & rw & (rd == src) & (rd != '0);
  endfunction

  logic a_ex, b_ex, a_wb, b_wb;

  // Per-source match against the EX and WB stages
  always_comb begin
    a_ex = hit(ex_valid_i, ex_reg_write_i, ex_rd_i, rs1_i);
    b_ex = hit(ex_valid_i, ex_reg_write_i, ex_rd_i, rs2_i) & rs2_used_i;
    a_wb = hit(wb_valid_i, wb_reg_write_i, wb_rd_i, rs1_i);
    b_wb = hit(wb_valid_i, wb_reg_write_i, wb_rd_i, rs2_i) & rs2_used_i;
  end

  // EX beats WB beats register file; without forwarding any match stalls
  always_comb begin
    fwd_a_o = FWD_RF;
    fwd_b_o = FWD_RF;
    if (FWD_EN) begin
      if (a_ex)      fwd_a_o = FWD_EX;
      else if (a_wb) fwd_a_o = FWD_WB;
      if (b_ex)      fwd_b_o = FWD_EX;
      else if (b_wb) fwd_b_o = FWD_WB;
    end
    stall_o = flush_i | (ex_is_load_i & (a_ex | b_ex))
            | (!FWD_EN & (a_ex | b_ex | a_wb | b_wb));
  end
endmodule

// File: rtl/pipelined_datapath.sv
// Three-stage operand-read / execute / writeback datapath with forwarding.
module pipelined_datapath
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          FWD_EN   = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_datapath_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [IDX_W-1:0] rd;
    alu_op_t          alu_op;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  pc;
  } ex_stage_t;

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [IDX_W-1:0] rd;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  pc4;
  } wb_stage_t;

  ex_stage_t       ex_q, ex_d;
  wb_stage_t       wb_q, wb_d;
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] alu_res, wb_data, rs1_val, rs2_val;
  fwd_sel_t        fwd_a, fwd_b;
  logic            stall;

  hazard_unit #(.IDX_W(IDX_W), .FWD_EN(FWD_EN)) u_hazard (
    .rs1_i          (bus.rs1),
    .rs2_i          (bus.rs2),
    .rs2_used_i     (~bus.ALUSrc),
    .ex_valid_i     (ex_q.ctrl.valid),
    .ex_reg_write_i (ex_q.ctrl.reg_write),
    .ex_is_load_i   (is_load(ex_q.ctrl)),
    .ex_rd_i        (ex_q.rd),
    .wb_valid_i     (wb_q.ctrl.valid),
    .wb_reg_write_i (wb_q.ctrl.reg_write),
    .wb_rd_i        (wb_q.rd),
    .flush_i        (bus.Flush),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .stall_o        (stall)
  );

  ALU #(.XLEN(XLEN)) u_alu (
    .a_i      (ex_q.op_a),
    .b_i      (ex_q.op_b),
    .op_i     (ex_q.alu_op),
    .result_o (alu_res)
  );

  // Source operand read with forwarding
  always_comb begin
    rs1_val = rf_q[bus.rs1];
    rs2_val = rf_q[bus.rs2];
    unique case (fwd_a)
      FWD_EX:  rs1_val = alu_res;
      FWD_WB:  rs1_val = wb_data;
      default: ;
    endcase
    unique case (fwd_b)
      FWD_EX:  rs2_val = alu_res;
      FWD_WB:  rs2_val = wb_data;
      default: ;
    endcase
  end

  // Next EX and WB stage contents; a stall or flush leaves a bubble in EX
  always_comb begin
    ex_d.ctrl.valid      = bus.InValid & ~stall;
    ex_d.ctrl.reg_write  = bus.RegWrite;
    ex_d.ctrl.mem_to_reg = bus.MemToReg;
    ex_d.rd              = bus.rd;
    ex_d.alu_op          = bus.ALUControl;
    ex_d.op_a            = rs1_val;
    ex_d.op_b            = bus.ALUSrc ? bus.Imm : rs2_val;
    ex_d.pc              = bus.PC;

    wb_d.ctrl            = ex_q.ctrl;
    wb_d.ctrl.valid      = ex_q.ctrl.valid & ~bus.Flush;
    wb_d.rd              = ex_q.rd;
    wb_d.result          = alu_res;
    wb_d.pc4             = ex_q.pc + XLEN'(4);
  end

  // Writeback source select
  always_comb begin
    wb_data = '0;
    unique case (wb_q.ctrl.mem_to_reg)
      WB_ALU:  wb_data = wb_q.result;
      WB_MEM:  wb_data = bus.ReadDataMem;
      WB_PC4:  wb_data = wb_q.pc4;
      default: wb_data = '0;
    endcase
  end

  // Pipeline stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      wb_q <= wb_d;
    end
  end

  // Register file; x0 is never written and so always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_q.ctrl.valid && wb_q.ctrl.reg_write && (wb_q.rd != '0)) begin
      rf_q[wb_q.rd] <= wb_data;
    end
  end

  assign bus.InReady       = ~stall;
  assign bus.MemAddr       = alu_res;
  assign bus.MemRead       = is_load(ex_q.ctrl);
  assign bus.WbValid       = wb_q.ctrl.valid;
  assign bus.WbRd          = wb_q.rd;
  assign bus.WriteBackData = wb_data;
endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: one forwarding instance and one non-forwarding instance.
module tb_pipelined_datapath;
  import riscv_pkg::*;

  typedef struct {
    logic        rw;
    alu_op_t     alu;
    logic        src;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
    wb_sel_t     m2r;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  logic clk, rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  q1[$], q0[$];
  sb_t  e1, e0;
  vec_t tbl[24];

  pipelined_datapath_if #(.XLEN(32), .NUM_REGS(32)) bus1 ();
  pipelined_datapath_if #(.XLEN(32), .NUM_REGS(32)) bus0 ();

  pipelined_datapath #(.XLEN(32), .NUM_REGS(32), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_datapath #(.XLEN(32), .NUM_REGS(32), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data at address a is a + 0x1234, one cycle later
  always @(posedge clk) begin
    bus1.ReadDataMem <= bus1.MemAddr + 32'h1234;
    bus0.ReadDataMem <= bus0.MemAddr + 32'h1234;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rw, input alu_op_t alu, input logic src,
                              input int rs1, input int rs2, input int rd,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input wb_sel_t m2r, input logic [31:0] exp, input int stalls);
    vec_t v;
    v.rw = rw; v.alu = alu; v.src = src;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.imm = imm; v.pc = pc; v.m2r = m2r; v.exp = exp; v.stalls = stalls;
    return v;
  endfunction

  task automatic drive(input bit sel, input vec_t v, input logic valid);
    if (sel) begin
      bus1.InValid = valid; bus1.RegWrite = v.rw; bus1.ALUControl = v.alu;
      bus1.ALUSrc = v.src; bus1.rs1 = v.rs1; bus1.rs2 = v.rs2; bus1.rd = v.rd;
      bus1.Imm = v.imm; bus1.PC = v.pc; bus1.MemToReg = v.m2r;
    end else begin
      bus0.InValid = valid; bus0.RegWrite = v.rw; bus0.ALUControl = v.alu;
      bus0.ALUSrc = v.src; bus0.rs1 = v.rs1; bus0.rs2 = v.rs2; bus0.rd = v.rd;
      bus0.Imm = v.imm; bus0.PC = v.pc; bus0.MemToReg = v.m2r;
    end
  endtask

  // Present one op, count stall cycles until accepted, queue its expected writeback
  task automatic issue(input bit sel, input vec_t v, input bit push);
    int  stalls;
    bit  done;
    sb_t s;
    stalls = 0;
    done   = 1'b0;
    s.rd   = v.rd;
    s.data = v.exp;
    drive(sel, v, 1'b1);
    while (!done && stalls <= 8) begin
      @(negedge clk);
      if (sel ? bus1.InReady : bus0.InReady) begin
        if (push) begin
          if (sel) q1.push_back(s); else q0.push_back(s);
        end
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: op rd=%0d still not accepted, required acceptance", v.rd);
    end
    check("stall_cycles", 32'(stalls), 32'(v.stalls));
    drive(sel, v, 1'b0);
  endtask

  // Writeback scoreboards
  always @(negedge clk) begin
    if (rst_n && bus1.WbValid) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wb1_unexpected: got rd=%0d data=0x%08h, required no writeback",
                 bus1.WbRd, bus1.WriteBackData);
      end else begin
        e1 = q1.pop_front();
        check("wb1_rd", 32'(bus1.WbRd), 32'(e1.rd));
        check("wb1_data", bus1.WriteBackData, e1.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus0.WbValid) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wb0_unexpected: got rd=%0d data=0x%08h, required no writeback",
                 bus0.WbRd, bus0.WriteBackData);
      end else begin
        e0 = q0.pop_front();
        check("wb0_rd", 32'(bus0.WbRd), 32'(e0.rd));
        check("wb0_data", bus0.WriteBackData, e0.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //       rw   alu       src rs1 rs2 rd  imm           pc            m2r      exp           stalls
    tbl[0]  = mk(1, ALU_ADD,  1,  0,  0,  1, 32'd5,        32'h0,        WB_ALU,  32'd5,        0);
    tbl[1]  = mk(1, ALU_ADD,  0,  1,  1,  2, 32'd0,        32'h4,        WB_ALU,  32'd10,       0);
    tbl[2]  = mk(1, ALU_SUB,  0,  2,  1,  3, 32'd0,        32'h8,        WB_ALU,  32'd5,        0);
    tbl[3]  = mk(1, ALU_ADD,  1,  3,  0,  4, 32'hFFFFFFFB, 32'hC,        WB_MEM,  32'h1234,     0);
    tbl[4]  = mk(1, ALU_ADD,  0,  4,  0,  5, 32'd0,        32'h10,       WB_ALU,  32'h1234,     1);
    tbl[5]  = mk(1, ALU_XOR,  1,  5,  0,  6, 32'hFF,       32'h14,       WB_ALU,  32'h12CB,     0);
    tbl[6]  = mk(1, ALU_AND,  0,  6,  4,  7, 32'd0,        32'h18,       WB_ALU,  32'h1200,     0);
    tbl[7]  = mk(1, ALU_OR,   0,  7,  6,  8, 32'd0,        32'h1C,       WB_ALU,  32'h12CB,     0);
    tbl[8]  = mk(1, ALU_ADD,  1,  0,  0,  0, 32'd9,        32'h20,       WB_ALU,  32'd9,        0);
    tbl[9]  = mk(1, ALU_ADD,  0,  0,  0,  9, 32'd0,        32'h24,       WB_ALU,  32'd0,        0);
    tbl[10] = mk(1, ALU_SUB,  0,  0,  1, 10, 32'd0,        32'h28,       WB_ALU,  32'hFFFFFFFB, 0);
    tbl[11] = mk(1, ALU_SLT,  0, 10,  1, 11, 32'd0,        32'h2C,       WB_ALU,  32'd1,        0);
    tbl[12] = mk(1, ALU_SLTU, 0, 10,  1, 12, 32'd0,        32'h30,       WB_ALU,  32'd0,        0);
    tbl[13] = mk(1, ALU_SLL,  1,  1,  0, 13, 32'd4,        32'h34,       WB_ALU,  32'h50,       0);
    tbl[14] = mk(1, ALU_SRA,  1, 10,  0, 14, 32'd1,        32'h38,       WB_ALU,  32'hFFFFFFFD, 0);
    tbl[15] = mk(0, ALU_ADD,  1,  0,  0,  1, 32'h77,       32'h3C,       WB_ALU,  32'h77,       0);
    tbl[16] = mk(1, ALU_ADD,  0,  1,  0, 15, 32'd0,        32'h40,       WB_ALU,  32'd5,        0);
    tbl[17] = mk(1, ALU_ADD,  1,  0,  0,  1, 32'h40,       32'hFFFFFFFC, WB_PC4,  32'd0,        0);
    tbl[18] = mk(1, ALU_ADD,  1,  0,  0, 18, 32'd3,        32'h44,       WB_ALU,  32'd3,        0);
    tbl[19] = mk(1, ALU_ADD,  0,  1,  0, 17, 32'd0,        32'h48,       WB_ALU,  32'd0,        0);
    tbl[20] = mk(1, ALU_ADD,  1,  0,  0, 19, 32'h55,       32'h4C,       WB_ZERO, 32'd0,        0);
    tbl[21] = mk(1, ALU_ADD,  1,  0,  0, 21, 32'd1,        32'h50,       WB_ALU,  32'd1,        0);
    tbl[22] = mk(1, ALU_ADD,  1,  0,  0, 21, 32'd2,        32'h54,       WB_ALU,  32'd2,        0);
    tbl[23] = mk(1, ALU_ADD,  0, 21, 21, 22, 32'd0,        32'h58,       WB_ALU,  32'd4,        0);

    v = mk(0, ALU_ADD, 0, 0, 0, 0, 32'd0, 32'd0, WB_ALU, 32'd0, 0);
    drive(1'b1, v, 1'b0);
    drive(1'b0, v, 1'b0);
    bus1.Flush = 1'b0;
    bus0.Flush = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_wbvalid",  32'(bus1.WbValid), 32'd0);
    check("rst_memread",  32'(bus1.MemRead), 32'd0);
    check("rst_memaddr",  bus1.MemAddr, 32'd0);
    check("rst_wbdata",   bus1.WriteBackData, 32'd0);
    check("rst_wbrd",     32'(bus1.WbRd), 32'd0);
    check("rst_inready",  32'(bus1.InReady), 32'd1);
    check("rst0_wbvalid", 32'(bus0.WbValid), 32'd0);
    check("rst0_inready", 32'(bus0.InReady), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table on the forwarding instance
    for (int i = 0; i < 24; i++) issue(1'b1, tbl[i], 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Flush of a PC+4 op in EX; the older op in WB still commits
    issue(1'b1, mk(1, ALU_ADD, 1, 0, 0, 23, 32'h33, 32'h60, WB_ALU, 32'h33, 0), 1'b1);
    issue(1'b1, mk(1, ALU_ADD, 1, 0, 0, 24, 32'h11, 32'h64, WB_ALU, 32'h11, 0), 1'b1);
    issue(1'b1, mk(1, ALU_ADD, 1, 0, 0, 23, 32'h40, 32'hFFFFFFFC, WB_PC4, 32'd0, 0), 1'b0);
    bus1.Flush = 1'b1;
    @(negedge clk);
    check("flush_inready", 32'(bus1.InReady), 32'd0);
    @(posedge clk);
    #1 bus1.Flush = 1'b0;
    @(negedge clk);
    check("flush_no_wb", 32'(bus1.WbValid), 32'd0);
    @(posedge clk);
    #1;
    issue(1'b1, mk(1, ALU_ADD, 0, 23, 0, 25, 32'd0, 32'h68, WB_ALU, 32'h33, 0), 1'b1);

    // Flush coinciding with a load-use stall discards the load
    issue(1'b1, mk(1, ALU_ADD, 1, 0, 0, 26, 32'h10, 32'h6C, WB_MEM, 32'h1244, 0), 1'b0);
    v = mk(1, ALU_ADD, 0, 26, 0, 27, 32'd0, 32'h70, WB_ALU, 32'd0, 0);
    drive(1'b1, v, 1'b1);
    bus1.Flush = 1'b1;
    @(negedge clk);
    check("flush_lu_inready", 32'(bus1.InReady), 32'd0);
    @(posedge clk);
    #1 bus1.Flush = 1'b0;
    issue(1'b1, v, 1'b1);

    // Non-forwarding instance: every RAW against EX/WB stalls
    issue(1'b0, mk(1, ALU_ADD, 1, 0, 0, 1, 32'd7, 32'h0, WB_ALU, 32'd7, 0), 1'b1);
    issue(1'b0, mk(1, ALU_ADD, 0, 1, 0, 2, 32'd0, 32'h4, WB_ALU, 32'd7, 2), 1'b1);
    issue(1'b0, mk(1, ALU_ADD, 1, 0, 0, 4, 32'd1, 32'h8, WB_ALU, 32'd1, 0), 1'b1);
    issue(1'b0, mk(1, ALU_ADD, 1, 0, 4, 6, 32'd3, 32'hC, WB_ALU, 32'd3, 0), 1'b1);
    issue(1'b0, mk(1, ALU_ADD, 0, 6, 4, 7, 32'd0, 32'h10, WB_ALU, 32'd4, 2), 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Reset with ops in flight: outputs clear at once, no register write survives
    issue(1'b1, mk(1, ALU_ADD, 1, 0, 0, 28, 32'd5, 32'h80, WB_ALU, 32'd5, 0), 1'b1);
    issue(1'b1, mk(1, ALU_ADD, 1, 0, 0, 29, 32'h20, 32'h84, WB_MEM, 32'h1254, 0), 1'b1);
    drive(1'b1, mk(1, ALU_ADD, 1, 0, 0, 30, 32'd6, 32'h88, WB_ALU, 32'd6, 0), 1'b1);
    check("pre_rst_memread", 32'(bus1.MemRead), 32'd1);
    #2 rst_n = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    check("mid_rst_wbvalid", 32'(bus1.WbValid), 32'd0);
    check("mid_rst_memread", 32'(bus1.MemRead), 32'd0);
    check("mid_rst_memaddr", bus1.MemAddr, 32'd0);
    check("mid_rst_wbdata",  bus1.WriteBackData, 32'd0);
    check("mid_rst_wbrd",    32'(bus1.WbRd), 32'd0);
    check("mid_rst_inready", 32'(bus1.InReady), 32'd1);
    repeat (2) @(posedge clk);
    bus1.InValid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i < 32; i++)
      issue(1'b1, mk(0, ALU_ADD, 0, i, i, 0, 32'd0, 32'd0, WB_ALU, 32'd0, 0), 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("sb1_drained", 32'(q1.size()), 32'd0);
    check("sb0_drained", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Three-stage (operand-read / execute / writeback) register-file-plus-ALU datapath, parametrised in data width and register count. It accepts decoded operations through a valid/ready handshake and forwards results from the execute and writeback stages. It stalls on load-use hazards and supports flushing of in-flight work. It sits between the decoder/control unit and a synchronous data memory.

## Interface
- `XLEN`, default 32: data width.
- `NUM_REGS`, default 32: register count, power of two ≥ 2; register 0 is hardwired zero.
- `FWD_EN`, default 1: 1 = forwarding enabled; 0 = every RAW hazard against EX/WB stalls.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `InValid`  in  1: decoded operation present.
- `InReady`  out  1: operation accepted this cycle when `InValid & InReady`.
- `RegWrite`  in  1: operation writes `rd`.
- `ALUControl`  in  `alu_op_t`: ALU operation.
- `ALUSrc`  in  1: 1 = B operand is `Imm`, rs2 unused.
- `rs1`, `rs2`, `rd`  in  `$clog2(NUM_REGS)` each: register indices.
- `Imm`  in  XLEN: immediate.
- `PC`  in  XLEN: operation PC.
- `MemToReg`  in  `wb_sel_t`, 2 bits: `WB_ALU`=00, `WB_MEM`=01, `WB_PC4`=10; 11 writes zero.
- `Flush`  in  1: discard operation in EX and refuse input this cycle.
- `MemAddr`  out  XLEN: EX-stage ALU result.
- `MemRead`  out  1: EX valid and `MemToReg==WB_MEM`.
- `ReadDataMem`  in  XLEN: memory data, valid the cycle after `MemRead`.
- `WbValid`  out  1: WB stage holds a valid operation.
- `WbRd`  out  index width: WB destination.
- `WriteBackData`  out  XLEN: WB mux result.

## Operation
- Accept cycle (A):
  - Read rs1/rs2 and apply forwarding.
  - Latch the operands, `rd`, `RegWrite`, `ALUControl`, `MemToReg` and `PC` into the EX register.
- EX cycle (A+1):
  - ALU computes `A op B`, where B = `ALUSrc ? Imm : rs2 value`.
  - Drive `MemAddr`/`MemRead`.
  - Latch the ALU result and `PC+4` (mod 2^XLEN) into the WB register.
- WB cycle (A+2):
  - Mux `WriteBackData`.
  - If `RegWrite & rd≠0`, the register file is written at the edge that ends A+2.
- Forwarding (`FWD_EN=1`), evaluated per source at A; source index 0 always reads 0.
  - Priority is EX match, then WB match, then register file.
  - A match requires the stage valid, its `RegWrite`=1, its rd = source, and rd ≠ 0.
  - An EX match to a non-load forwards the ALU result.
  - A WB match forwards `WriteBackData`.
- Stall (InReady=0) when any of the following holds:
  - An EX-stage load matches a used source (load-use; one bubble).
  - `FWD_EN=0` and any EX or WB match exists (up to two bubbles).
  - `Flush`=1.
- Stalling inserts a bubble into EX; WB always advances.
- `Flush`=1: EX valid is cleared at the edge, so nothing enters WB next cycle. The WB operation completes normally.
- Writes to x0 are discarded. The ALU `Zero` output is unused.

## Timing
- Latency: accept at A → `WbValid`/`WriteBackData` at A+2 → architecturally visible to a read at A+3. Reads at A+1 and A+2 see the value through forwarding.
- Throughput: one operation per cycle absent hazards.
- `InReady` is combinational from `Flush` and the hazard compare; it does not depend on `InValid`.
- Reset (asserted asynchronously, released synchronously to clk):
  - All valids are 0 and all registers are 0.
  - `WbValid`=0, `MemRead`=0, `MemAddr`=0, `WriteBackData`=0, `WbRd`=0, `InReady`=1.
- Reset mid-operation drops all in-flight operations without performing any register write.
- `Flush` and a load-use stall in the same cycle: the flush wins and the EX load is discarded.
- `InValid=0` inserts a bubble into EX.

## Structure
- `riscv_pkg` gets:
  - `wb_sel_t` enum.
  - `fwd_sel_t` enum (`FWD_RF`, `FWD_EX`, `FWD_WB`).
  - A stage-register struct type: valid, rd, RegWrite, ALUControl, MemToReg, operands, PC.
- The existing `ALU` module is reused.
- One sub-module, `hazard_unit`: forwarding selects and the stall decision (combinational), parametrised by index width and `FWD_EN`.
- The register file is internal, parametrised by `XLEN`/`NUM_REGS`.

## Test plan
- Back-to-back ADDI x1,x0,5; ADD x2,x1,x1 (`FWD_EN=1`) → no stall; WB shows x1=5, then x2=10, on consecutive cycles.
- Load x3 (`ReadDataMem`=0x1234) then ADD x4,x3,x0 → exactly one cycle with `InReady`=0; x4=0x1234.
- `FWD_EN=0`, ADDI x1,x0,7 then ADD x2,x1,x0 → two stall cycles; x2=7.
- ADDI x0,x0,9 then ADD x5,x0,x0 → x5=0; `WbValid`=1 for both ops; x0 still reads 0.
- JAL-type op (`MemToReg`=10, PC=0xFFFFFFFC, rd=1) → x1=0x00000000 (wrap); with `Flush` asserted the cycle it is in EX → no WB, and the preceding WB op still commits.
- Assert `rst_n`=0 while three ops are in flight → outputs are at reset values immediately; no register is written; after release, x1..x31 read 0.
